audio_echo: RTL
===============

# audio_echo

Feedback echo/delay effect sitting directly between the audio driver's capture and playback sides. On every `advance` pulse it takes the ADC stereo sample and returns the processed stereo sample for the driver to play back on the following `advance`. Each channel computes y[n] = sat(x[n] + (y[n−D] >>> DECAY_SHIFT)), using a circular buffer of past outputs held in on-chip RAM.

## Interface

Parameters:
- DEPTH_LOG2, 12, log2 of buffer depth in stereo samples (4096 ≈ 85 ms at 48 kHz)
- DECAY_SHIFT, 1, arithmetic right shift applied to the delayed sample (feedback gain 2^−DECAY_SHIFT)

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- advance  in  1  one-cycle sample strobe from the audio driver
- adc_left, adc_right  in  24  signed two's-complement input samples, valid while advance=1
- enable  in  1  1 = echo active, 0 = bypass; sampled on the advance cycle
- delay  in  DEPTH_LOG2  echo delay D in samples; 0 means 2^DEPTH_LOG2; sampled on the advance cycle
- dac_left, dac_right  out  24  signed output samples, registered, stable across every advance cycle
- busy  out  1  high during buffer clear and during per-sample processing

## Operation

- Storage: single-port synchronous RAM, 2^DEPTH_LOG2 × 48 bits ({L,R}). One access per cycle, 1-cycle read latency.
- Write pointer: wr_ptr, DEPTH_LOG2 bits, wraps modulo 2^DEPTH_LOG2.
- Read address: (wr_ptr − delay_q) mod 2^DEPTH_LOG2. When delay_q = 0 this equals wr_ptr, which holds the oldest sample, giving a full-depth delay.
- FSM states:
  - CLEAR: writes 0 to address clr_cnt, then increments clr_cnt. After writing the last address → IDLE. Advance pulses are ignored and dac outputs stay 0.
  - IDLE: on advance, latch x_l/x_r, enable_q and delay_q → READ.
  - READ: drive the read address to the RAM → MIX.
  - MIX: RAM data d is valid. Compute the sum per channel in 25 bits as x + (d >>> DECAY_SHIFT), then saturate to [−8388608, 8388607]. If enable_q = 0, y = x. Register y → WRITE.
  - WRITE: RAM[wr_ptr] ← {y_l, y_r}, dac_left/right ← y, wr_ptr ← wr_ptr+1 → IDLE.
- Bypass still writes y = x into the buffer, so re-enabling echoes recent input.
- An advance arriving in READ/MIX/WRITE is ignored; no sample is captured. It cannot occur with the driver's ~1042-cycle spacing.

## Timing

- Reset values: state=CLEAR, clr_cnt=0, wr_ptr=0, dac_left=dac_right=0, busy=1.
- CLEAR lasts exactly 2^DEPTH_LOG2 cycles after reset deasserts.
- Advance seen at edge E0. READ occupies the cycle after E0, MIX the next, WRITE the next. dac updates at E3, and busy drops at E3.
- The driver consumes the sample captured at advance n on advance n+1. End-to-end latency is one sample period.
- dac outputs change only at the WRITE edge, never in a cycle where advance=1.
- Reset asserted in any state aborts the operation immediately and restarts CLEAR. Buffer contents are re-zeroed.
- Saturation boundary: 8388607 + any positive value → 8388607; −8388608 + any negative value → −8388608.

## Test plan

Bench uses DEPTH_LOG2=4, DECAY_SHIFT=1, with advance pulsed every 20 cycles.

- Reset → busy=1 for exactly 16 cycles, dac=0 throughout; advance pulses during CLEAR leave dac=0.
- enable=1, delay=3, impulse x=0x100000 on L then zeros → dac_left on successive advances: 0, 0x100000, 0, 0, 0x080000, 0, 0, 0x040000, …; R stays 0.
- delay=0, impulse 1000 → echo of 500 appears 16 samples after the impulse.
- Saturation: constant x=0x7FFFF0, delay=1 → output climbs and clamps at 0x7FFFFF; constant −0x7FFFF0 clamps at 0x800000.
- enable=0 with sequence 5, −7, 9 → dac shows the same values one advance later. Then enable=1, delay=2 → the first echo equals the earlier bypassed input >>> 1.
- Reset asserted in MIX → dac=0 next cycle, busy stays high for 16 cycles, and the previous echo content is absent afterward.

Source files
------------

// File: rtl/audio_echo_if.sv
// Driver-facing bundle for the echo block: capture strobe/samples in, playback samples and busy out.
interface audio_echo_if #(
  parameter int DEPTH_LOG2 = 12
);
  logic                  advance;
  logic signed [23:0]    adc_left;
  logic signed [23:0]    adc_right;
  logic                  enable;
  logic [DEPTH_LOG2-1:0] delay;
  logic signed [23:0]    dac_left;
  logic signed [23:0]    dac_right;
  logic                  busy;

  modport master (
    output advance, adc_left, adc_right, enable, delay,
    input  dac_left, dac_right, busy
  );

  modport slave (
    input  advance, adc_left, adc_right, enable, delay,
    output dac_left, dac_right, busy
  );
endinterface

// File: rtl/audio_echo.sv
// Stereo feedback echo: y = sat(x + (y[n-D] >>> DECAY_SHIFT)) per channel,
// past outputs kept in a single-port RAM walked by a small sequencer.
module audio_echo_lane #(
  parameter int VEC_W       = 24,
  parameter int DECAY_SHIFT = 1
) (
  input  logic [VEC_W-1:0] x,
  input  logic [VEC_W-1:0] d,
  input  logic             en,
  output logic [VEC_W-1:0] y
);
  logic signed [VEC_W-1:0] d_sh;
  logic        [VEC_W:0]   sum;

  assign d_sh = $signed(d) >>> DECAY_SHIFT;
  assign sum  = {x[VEC_W-1], x} + {d_sh[VEC_W-1], d_sh};

  // One guard bit: overflow iff the top two sum bits disagree.
  always_comb begin
    y = sum[VEC_W-1:0];
    if (!en)
      y = x;
    else if (sum[VEC_W] != sum[VEC_W-1])
      y = sum[VEC_W] ? {1'b1, {(VEC_W-1){1'b0}}} : {1'b0, {(VEC_W-1){1'b1}}};
  end
endmodule

module audio_echo #(
  parameter int DEPTH_LOG2  = 12,
  parameter int DECAY_SHIFT = 1
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  audio_echo_if.slave bus
);
  localparam int NUM_LANES = 2;
  localparam int VEC_W     = 24;
  localparam int DEPTH     = 1 << DEPTH_LOG2;

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_READ, S_MIX, S_WRITE} state_t;

  state_t                               state;
  logic [DEPTH_LOG2-1:0]                clr_cnt, wr_ptr, delay_q, ram_addr;
  logic [NUM_LANES-1:0][VEC_W-1:0]      x_q, y_q, mix_y, dac_q;
  logic [NUM_LANES-1:0][VEC_W-1:0]      ram_rdata, ram_wdata;
  logic                                 ram_we, enable_q, busy_q;
  logic [NUM_LANES*VEC_W-1:0]           mem [0:DEPTH-1];

  // Lane 1 is left, lane 0 right, so a RAM word is {L,R}.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = wr_ptr;
    ram_wdata = y_q;
    case (state)
      S_CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = clr_cnt;
        ram_wdata = '0;
      end
      S_READ:  ram_addr = wr_ptr - delay_q;
      S_WRITE: ram_we   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (ram_we)
      mem[ram_addr] <= ram_wdata;
    else
      ram_rdata <= mem[ram_addr];
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    audio_echo_lane #(
      .VEC_W       (VEC_W),
      .DECAY_SHIFT (DECAY_SHIFT)
    ) u_lane (
      .x  (x_q[i]),
      .d  (ram_rdata[i]),
      .en (enable_q),
      .y  (mix_y[i])
    );
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= S_CLEAR;
      clr_cnt  <= '0;
      wr_ptr   <= '0;
      delay_q  <= '0;
      enable_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      dac_q    <= '0;
      busy_q   <= 1'b1;
    end else begin
      case (state)
        S_CLEAR: begin
          clr_cnt <= clr_cnt + DEPTH_LOG2'(1);
          if (clr_cnt == '1) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        end
        S_IDLE: if (bus.advance) begin
          x_q      <= {bus.adc_left, bus.adc_right};
          enable_q <= bus.enable;
          delay_q  <= bus.delay;
          busy_q   <= 1'b1;
          state    <= S_READ;
        end
        S_READ:  state <= S_MIX;
        S_MIX: begin
          y_q   <= mix_y;
          state <= S_WRITE;
        end
        S_WRITE: begin
          dac_q  <= y_q;
          wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

  assign bus.dac_left  = dac_q[1];
  assign bus.dac_right = dac_q[0];
  assign bus.busy      = busy_q;
endmodule
